// File: rtl/switch_led_ctrl_if.sv
// Switch/LED bundle for switch_led_ctrl: raw switch levels, mode select and
// registered LED drive. The master side (board stimulus) drives sw/mode and
// observes led; the slave side (the controller) does the reverse.
interface switch_led_ctrl_if #(
    parameter int N = 16
);
    logic [N-1:0] sw;
    logic [1:0]   mode;
    logic [N-1:0] led;

    modport master (
        output sw,
        output mode,
        input  led
    );

    modport slave (
        input  sw,
        input  mode,
        output led
    );
endinterface

// File: rtl/switch_led_ctrl.sv
// switch_led_ctrl: N-channel switch-to-LED controller.
// Each raw switch is passed through a 2-flop synchroniser and a per-channel
// debouncer; the debounced level drives the LED register through one of four
// modes (00 direct, 01 toggle-latch, 10 blink, 11 inverted).
// Optional feature macro: SWITCH_LED_BLINK_EN. When defined, a blink
// prescaler and phase flop are built and mode 10 blinks; when undefined,
// mode 10 behaves exactly like mode 00 and BLINK_DIV has no effect.
module switch_led_ctrl #(
    parameter int N               = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_DIV       = 8
) (
    input  logic               clk,
    input  logic               reset,
    switch_led_ctrl_if.slave   bus
);

    // Counter width leaves room for DEBOUNCE_CYCLES-1 even when it is a power of two.
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard on the legal parameter ranges.
    if ((N < 1) || (N > 32) || (DEBOUNCE_CYCLES < 1) || (BLINK_DIV < 1)) begin : g_bad_param
        $error("switch_led_ctrl: parameter out of range");
    end

    logic [N-1:0]  sync1_r;
    logic [N-1:0]  sync2_r;
    logic [N-1:0]  db_r;
    logic [N-1:0]  tog_r;
    logic [N-1:0]  led_r;
    logic [CW-1:0] cnt_r     [N];

    logic [N-1:0]  db_nxt_s;
    logic [CW-1:0] cnt_nxt_s [N];
    logic [N-1:0]  rise_s;
    logic [N-1:0]  blink_mask_s;
    logic [N-1:0]  led_nxt_s;

    // Selects the LED drive for the given mode from the debounced state.
    function automatic logic [N-1:0] led_select(
        input logic [1:0]   mode_v,
        input logic [N-1:0] db_v,
        input logic [N-1:0] tog_v,
        input logic [N-1:0] mask_v
    );
        logic [N-1:0] res;
        case (mode_v)
            2'b00:   res = db_v;
            2'b01:   res = tog_v;
            2'b10:   res = db_v & mask_v;
            2'b11:   res = ~db_v;
            default: res = db_v;
        endcase
        return res;
    endfunction

    // Two-flop synchroniser bringing the asynchronous switch pins into clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= bus.sw;
            sync2_r <= sync1_r;
        end
    end

    // Per-channel debounce next-state: count consecutive cycles the
    // synchronised level differs from the accepted level, accept at the limit.
    always_comb begin
        db_nxt_s = db_r;
        for (int i = 0; i < N; i++) begin
            cnt_nxt_s[i] = '0;
            if (sync2_r[i] == db_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == CNT_LAST) begin
                db_nxt_s[i]  = sync2_r[i];
                cnt_nxt_s[i] = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
        // Rising edge of the accepted level; tog flips on the same edge db rises
        // so mode 01 shows the change one edge later, like the other modes.
        rise_s = db_nxt_s & ~db_r;
    end

    // Debounced level, counters and toggle latches; tog tracks in every mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_r  <= '0;
            tog_r <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            db_r  <= db_nxt_s;
            tog_r <= tog_r ^ rise_s;
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

`ifdef SWITCH_LED_BLINK_EN
    localparam int            PW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);

    logic [PW-1:0] pre_r;
    logic          phase_r;

    // Free-running blink prescaler; the phase flips each time it wraps to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_r   <= '0;
            phase_r <= 1'b0;
        end else if (pre_r == PRE_LAST) begin
            pre_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            pre_r   <= pre_r + PW'(1);
            phase_r <= phase_r;
        end
    end

    assign blink_mask_s = {N{phase_r}};
`else
    // Without blinking, mode 10 passes the debounced level straight through.
    assign blink_mask_s = {N{1'b1}};
`endif

    // LED next value from the currently selected mode.
    always_comb begin
        led_nxt_s = led_select(bus.mode, db_r, tog_r, blink_mask_s);
    end

    // LED drive register; the pins come straight from this flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r <= '0;
        end else begin
            led_r <= led_nxt_s;
        end
    end

    assign bus.led = led_r;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed bench for switch_led_ctrl (N=16, DEBOUNCE_CYCLES=16, BLINK_DIV=8).
// Expected LED values are queued when stimulus is applied and popped when
// the LED output is sampled on the falling clock edge.
module tb_switch_led_ctrl;

    localparam int N  = 16;
    localparam int D  = 16;
    localparam int BD = 8;

    logic clk = 1'b0;
    logic reset;

    switch_led_ctrl_if #(.N(N)) bus ();

    switch_led_ctrl #(
        .N               (N),
        .DEBOUNCE_CYCLES (D),
        .BLINK_DIV       (BD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release (1 after the first edge).
    int ec;
    always @(posedge clk or posedge reset) begin
        if (reset) ec <= 0;
        else       ec <= ec + 1;
    end

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q [$];
    string        tag_q [$];

    task automatic push_exp(input string tag, input logic [N-1:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_led();
        logic [N-1:0] e;
        string        t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", bus.led);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (bus.led === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", t, bus.led, e);
            end
        end
    endtask

    // Advance n rising edges, returning on the following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [N-1:0] tog_m;
    logic [N-1:0] blink_exp;

    initial begin
        // ---- reset with all switches held high ----
        reset    = 1'b1;
        bus.sw   = 16'hFFFF;
        bus.mode = 2'b00;
        step(3);
        push_exp("reset_hold", 16'h0000);
        check_led();
        reset = 1'b0;                 // next rising edge is edge 0
        push_exp("rst_edge17", 16'h0000);
        step(18);                     // edges 0..17
        check_led();
        push_exp("rst_edge18", 16'hFFFF);
        step(1);                      // edge 18
        check_led();

        // ---- mode 00: short pulse is rejected, full hold is accepted ----
        bus.sw = 16'h0000;
        push_exp("all_low", 16'h0000);
        step(20);
        check_led();
        bus.sw = 16'h0008;
        step(10);
        bus.sw = 16'h0000;
        for (int i = 0; i < 25; i++) begin
            push_exp("pulse10", 16'h0000);
            step(1);
            check_led();
        end
        bus.sw = 16'h0008;
        push_exp("hold_edge17", 16'h0000);
        step(18);
        check_led();
        push_exp("hold_edge18", 16'h0008);
        step(1);
        check_led();

        // ---- mode 01: toggle latch from a fresh reset ----
        bus.sw   = 16'h0000;
        bus.mode = 2'b01;
        reset    = 1'b1;
        #1;
        push_exp("async_clear", 16'h0000);
        check_led();
        step(2);
        reset = 1'b0;
        tog_m = 16'h0000;
        push_exp("tog_init", tog_m);
        step(20);
        check_led();
        for (int k = 0; k < 3; k++) begin
            bus.sw = 16'h0001;
            push_exp("tog_press_e17", tog_m);
            step(18);
            check_led();
            tog_m = tog_m ^ 16'h0001;
            push_exp("tog_press_e18", tog_m);
            step(1);
            check_led();
            bus.sw = 16'h0000;
            push_exp("tog_release", tog_m);
            step(20);
            check_led();
        end

        // ---- mode 10: blink on the debounced lower byte ----
        bus.mode = 2'b00;
        bus.sw   = 16'h00FF;
        push_exp("blink_setup", 16'h00FF);
        step(20);
        check_led();
        bus.mode = 2'b10;
        for (int i = 0; i < 40; i++) begin
            step(1);
`ifdef SWITCH_LED_BLINK_EN
            // led after edge ec uses the phase after edge ec-1
            blink_exp = ((((ec - 1) / BD) % 2) == 1) ? 16'h00FF : 16'h0000;
`else
            blink_exp = 16'h00FF;
`endif
            push_exp("blink", blink_exp);
            check_led();
        end

        // ---- mode 11 inverted, then back to direct ----
        bus.mode = 2'b11;
        bus.sw   = 16'hA5A5;
        push_exp("inverted", 16'h5A5A);
        step(20);
        check_led();
        bus.mode = 2'b00;
        push_exp("mode_to_00", 16'hA5A5);
        step(1);
        check_led();

        // ---- reset in the middle of a debounce count on sw[7] ----
        bus.sw = 16'h0000;
        push_exp("pre_midcount", 16'h0000);
        step(20);
        check_led();
        bus.sw = 16'h0080;
        step(12);                     // edges 0..11: cnt[7] reaches 10
        reset = 1'b1;
        #1;
        push_exp("midcount_reset", 16'h0000);
        check_led();
        step(3);
        reset = 1'b0;                 // next rising edge is edge 0
        push_exp("requal_edge17", 16'h0000);
        step(18);
        check_led();
        push_exp("requal_edge18", 16'h0080);
        step(1);
        check_led();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
